// File: rtl/prbs5_checker.sv
// PRBS5 checker: locks onto a 5-bit Galois LFSR stream carried as parallel state
// samples, then counts mispredicted samples while locked.
// Optional lock statistics (sample_cnt, period_done) are built only when the
// macro PRBS5_CHK_STATS_EN is defined; otherwise both outputs are tied to 0.
module prbs5_checker #(
    parameter int unsigned LOCK_MATCHES    = 4,
    parameter int unsigned LOSS_MISMATCHES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [4:0]  in_data,
    input  logic        err_clr,
    output logic        locked,
    output logic        lost_lock,
    output logic [7:0]  err_cnt,
    output logic [15:0] sample_cnt,
    output logic        period_done
);

    localparam logic [3:0] LockMatchesW    = 4'(LOCK_MATCHES);
    localparam logic [3:0] LossMismatchesW = 4'(LOSS_MISMATCHES);

    typedef enum logic [0:0] {StSearch, StLocked} state_e;

    state_e     state_q;
    logic [4:0] pred_q;
    logic       pred_loaded_q;
    logic [3:0] match_cnt_q;
    logic [3:0] miss_cnt_q;

    logic pred_hit;
    logic lock_sample;
    logic drop_lock;

    // Same next-state function as the upstream generator.
    function automatic logic [4:0] next5(input logic [4:0] q);
        return {q[3], q[2], q[1] ^ q[4], q[0], q[4]};
    endfunction

    assign pred_hit    = (in_data == pred_q);
    assign lock_sample = (state_q == StLocked) && in_valid;
    // Mismatch that reaches the loss threshold; LOCKED -> SEARCH on this edge.
    assign drop_lock   = lock_sample && !pred_hit && ((miss_cnt_q + 4'd1) == LossMismatchesW);

    // Search/lock FSM with registered status outputs and error counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StSearch;
            pred_q        <= '0;
            pred_loaded_q <= 1'b0;
            match_cnt_q   <= '0;
            miss_cnt_q    <= '0;
            locked        <= 1'b0;
            lost_lock     <= 1'b0;
            err_cnt       <= '0;
        end else begin
            lost_lock <= 1'b0;
            if (err_clr) begin
                err_cnt <= '0;
            end
            if (in_valid) begin
                unique case (state_q)
                    StSearch: begin
                        if (in_data == 5'd0) begin
                            // All-zero is a dead LFSR state: never a valid sync point.
                            match_cnt_q <= '0;
                        end else if (pred_loaded_q && pred_hit) begin
                            pred_q <= next5(in_data);
                            if ((match_cnt_q + 4'd1) == LockMatchesW) begin
                                state_q     <= StLocked;
                                locked      <= 1'b1;
                                miss_cnt_q  <= '0;
                                match_cnt_q <= '0;
                            end else begin
                                match_cnt_q <= match_cnt_q + 4'd1;
                            end
                        end else begin
                            // Resync on this sample.
                            pred_q        <= next5(in_data);
                            pred_loaded_q <= 1'b1;
                            match_cnt_q   <= '0;
                        end
                    end
                    StLocked: begin
                        // Free-running prediction, independent of the received data.
                        pred_q <= next5(pred_q);
                        if (pred_hit) begin
                            miss_cnt_q <= '0;
                        end else begin
                            if (!err_clr && (err_cnt != 8'hff)) begin
                                err_cnt <= err_cnt + 8'd1;
                            end
                            if (drop_lock) begin
                                state_q       <= StSearch;
                                locked        <= 1'b0;
                                lost_lock     <= 1'b1;
                                match_cnt_q   <= '0;
                                miss_cnt_q    <= '0;
                                pred_loaded_q <= 1'b0;
                            end else begin
                                miss_cnt_q <= miss_cnt_q + 4'd1;
                            end
                        end
                    end
                    default: state_q <= StSearch;
                endcase
            end
        end
    end

`ifdef PRBS5_CHK_STATS_EN
    logic [4:0] period_q;

    // Lock statistics: saturating sample count and a mod-31 period pulse.
    always_ff @(posedge clk) begin
        if (rst || drop_lock) begin
            sample_cnt  <= '0;
            period_q    <= '0;
            period_done <= 1'b0;
        end else if (lock_sample) begin
            if (sample_cnt != 16'hffff) begin
                sample_cnt <= sample_cnt + 16'd1;
            end
            if (period_q == 5'd30) begin
                period_q    <= '0;
                period_done <= 1'b1;
            end else begin
                period_q    <= period_q + 5'd1;
                period_done <= 1'b0;
            end
        end else begin
            period_done <= 1'b0;
        end
    end
`else
    assign sample_cnt  = '0;
    assign period_done = 1'b0;
`endif

endmodule
